// File: rtl/bp_types.sv
// Types shared by the perceptron predictor (pbp) and the history checkpoint
// block (ghr_ckpt). Both sides must agree on the history length.
package bp_types;
  localparam int BP_HIST_LEN = 12;
  typedef logic [BP_HIST_LEN-1:0] hist_t;
endpackage

// File: rtl/ghr_ckpt_if.sv
// Fetch / resolve bundle for ghr_ckpt.
//   IF side     : if_br_valid, if_pred_taken in; ghr_out, ckpt_full out
//   EX/MEM side : res_valid, res_taken, res_mispred in; exmem_hist out
//   status      : count, err out
// slave = ghr_ckpt, master = fetch/resolve driver.
interface ghr_ckpt_if #(
  parameter int HIST_LEN = bp_types::BP_HIST_LEN,
  parameter int DEPTH    = 4
);
  localparam int CW = $clog2(DEPTH+1);

  logic                if_br_valid;
  logic                if_pred_taken;
  logic [HIST_LEN-1:0] ghr_out;
  logic                ckpt_full;
  logic                res_valid;
  logic                res_taken;
  logic                res_mispred;
  logic [HIST_LEN-1:0] exmem_hist;
  logic [CW-1:0]       count;
  logic                err;

  modport slave (
    input  if_br_valid, if_pred_taken, res_valid, res_taken, res_mispred,
    output ghr_out, ckpt_full, exmem_hist, count, err
  );

  modport master (
    output if_br_valid, if_pred_taken, res_valid, res_taken, res_mispred,
    input  ghr_out, ckpt_full, exmem_hist, count, err
  );
endinterface

// File: rtl/ghr_ckpt_fifo.sv
// ckpt_fifo: checkpoint FIFO of W-bit entries, DEPTH deep (power of 2).
//   push/din : write din at tail (caller guarantees not full)
//   pop      : drop head entry (caller guarantees not empty)
//   clr      : empty the FIFO; overrides push/pop
//   head_dout: entry at head, combinational from storage
//   count    : occupied entries
// Entries reset to 0 so head_dout reads 0 out of reset.
module ckpt_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head_dout,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;

  // Pointers are exactly PW bits wide, so +1 wraps modulo DEPTH.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = din;
        tail_d        = tail_q + 1'b1;
      end
      if (pop) head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_dout = mem_q[head_q];
  assign count     = count_q;
endmodule

// File: rtl/ghr_ckpt.sv
// ghr_ckpt: speculative global history with per-branch checkpoints.
//   clk, rst    : clock, async active-low reset
//   bus (slave) : fetch push, EX/MEM resolve, history/status outputs
// spec shifts in each predicted direction at fetch; the pre-shift value is
// checkpointed so EX/MEM can train pbp on the history it predicted with.
// arch tracks resolved outcomes; a mispredict copies it into spec and
// discards every younger (wrong-path) checkpoint.
module ghr_ckpt
  import bp_types::*;
#(
  parameter int HIST_LEN = BP_HIST_LEN,
  parameter int DEPTH    = 4,
  localparam int CW      = $clog2(DEPTH+1)
) (
  input  logic     clk,
  input  logic     rst,
  ghr_ckpt_if.slave bus
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [HIST_LEN-1:0] spec_q, spec_d;
  logic [HIST_LEN-1:0] arch_q, arch_d;
  logic                err_q, err_d;
  logic [HIST_LEN-1:0] arch_nxt;
  logic [HIST_LEN-1:0] head_hist;
  logic [CW-1:0]       cnt;
  logic                full, empty;
  logic                do_push, do_pop, do_fix;

  // Full/empty come from registered count only: no same-cycle pop credit,
  // which keeps resolve off the fetch-stall path.
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  assign do_fix   = bus.res_valid &&  bus.res_mispred && !empty;
  assign do_pop   = bus.res_valid && !bus.res_mispred && !empty;
  // A push racing a mispredict is wrong-path; the repair wins.
  assign do_push  = bus.if_br_valid && !full && !(bus.res_valid && bus.res_mispred);
  assign arch_nxt = {arch_q[HIST_LEN-2:0], bus.res_taken};

  always_comb begin
    spec_d = spec_q;
    arch_d = arch_q;
    err_d  = err_q | (bus.if_br_valid & full) | (bus.res_valid & empty);
    if (do_pop || do_fix) arch_d = arch_nxt;
    if (do_fix)       spec_d = arch_nxt;
    else if (do_push) spec_d = {spec_q[HIST_LEN-2:0], bus.if_pred_taken};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_q <= '0;
      arch_q <= '0;
      err_q  <= 1'b0;
    end else begin
      spec_q <= spec_d;
      arch_q <= arch_d;
      err_q  <= err_d;
    end
  end

  ckpt_fifo #(.W(HIST_LEN), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (do_push),
    .pop      (do_pop),
    .clr      (do_fix),
    .din      (spec_q),
    .head_dout(head_hist),
    .count    (cnt)
  );

  assign bus.ghr_out    = spec_q;
  assign bus.ckpt_full  = full;
  assign bus.exmem_hist = head_hist;
  assign bus.count      = cnt;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_ghr_ckpt.sv
// Bench for ghr_ckpt: queue-based reference model checked every cycle, plus
// hand-computed expectations at the directed scenario points.
module tb_ghr_ckpt;
  import bp_types::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ghr_ckpt_if #(.HIST_LEN(BP_HIST_LEN), .DEPTH(DEPTH)) bus ();
  ghr_ckpt #(.HIST_LEN(BP_HIST_LEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of checkpointed histories plus two histories.
  hist_t m_spec, m_arch;
  hist_t m_q[$];
  bit    m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_spec = '0; m_arch = '0; m_err = 1'b0; m_q.delete();
  endtask

  // Apply the rules to the inputs present at the clock edge.
  task automatic model_step();
    bit    full, empty, bv, rv, rm;
    hist_t old_spec;
    bv = bus.if_br_valid; rv = bus.res_valid; rm = bus.res_mispred;
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    old_spec = m_spec;
    if (bv && full)  m_err = 1'b1;
    if (rv && empty) m_err = 1'b1;
    if (rv && !empty) begin
      m_arch = hist_t'({m_arch, bus.res_taken});
      if (rm) begin
        m_spec = m_arch;
        m_q.delete();
      end else begin
        void'(m_q.pop_front());
      end
    end
    if (bv && !full && !(rv && rm)) begin
      m_q.push_back(old_spec);
      m_spec = hist_t'({old_spec, bus.if_pred_taken});
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ghr_out",   32'(bus.ghr_out),   32'(m_spec));
      chk("count",     32'(bus.count),     32'(m_q.size()));
      chk("ckpt_full", 32'(bus.ckpt_full), 32'(m_q.size() == DEPTH));
      chk("err",       32'(bus.err),       32'(m_err));
      if (m_q.size() != 0) chk("exmem_hist", 32'(bus.exmem_hist), 32'(m_q[0]));
    end
  end

  // One clock: drive at the negedge, model the posedge, return at next negedge.
  task automatic cyc(input bit bv, input bit pt, input bit rv, input bit rt, input bit rm);
    bus.if_br_valid = bv; bus.if_pred_taken = pt;
    bus.res_valid = rv; bus.res_taken = rt; bus.res_mispred = rm;
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.if_br_valid = 1'b0; bus.res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.if_br_valid = 1'b0; bus.if_pred_taken = 1'b0;
    bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.res_mispred = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst ghr_out", 32'(bus.ghr_out), 32'h0);
    chk("rst count",   32'(bus.count), 32'h0);
    chk("rst full",    32'(bus.ckpt_full), 32'h0);
    chk("rst exmem",   32'(bus.exmem_hist), 32'h0);
    chk("rst err",     32'(bus.err), 32'h0);
    rst_n = 1'b1;

    // Push T, N, T.
    cyc(1,1,0,0,0); cyc(1,0,0,0,0); cyc(1,1,0,0,0);
    chk("s2 ghr_out", 32'(bus.ghr_out), 32'h005);
    chk("s2 count",   32'(bus.count), 32'd3);
    chk("s2 exmem",   32'(bus.exmem_hist), 32'h000);

    // Correct resolve, taken.
    cyc(0,0,1,1,0);
    chk("s3 count",   32'(bus.count), 32'd2);
    chk("s3 exmem",   32'(bus.exmem_hist), 32'h001);
    chk("s3 ghr_out", 32'(bus.ghr_out), 32'h005);

    // Mispredict, actually taken: arch 001 -> 003.
    cyc(0,0,1,1,1);
    chk("s4 ghr_out", 32'(bus.ghr_out), 32'h003);
    chk("s4 count",   32'(bus.count), 32'd0);
    chk("s4 full",    32'(bus.ckpt_full), 32'd0);

    // Resolve while empty sets sticky err and changes nothing else.
    cyc(0,0,1,1,0);
    chk("empty res err", 32'(bus.err), 32'd1);
    chk("empty res ghr", 32'(bus.ghr_out), 32'h003);
    cyc(0,0,0,0,0);
    chk("err sticky", 32'(bus.err), 32'd1);

    // Fill, overflow, then push + correct resolve at count 3.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1,1,0,0,0);
    chk("s5 full",    32'(bus.ckpt_full), 32'd1);
    chk("s5 ghr_out", 32'(bus.ghr_out), 32'h00F);
    chk("s5 err0",    32'(bus.err), 32'd0);
    cyc(1,1,0,0,0);
    chk("s5 ovf ghr", 32'(bus.ghr_out), 32'h00F);
    chk("s5 ovf err", 32'(bus.err), 32'd1);
    chk("s5 ovf cnt", 32'(bus.count), 32'd4);
    cyc(0,0,1,1,0);
    chk("s5 cnt3",    32'(bus.count), 32'd3);
    cyc(1,1,1,1,0);
    chk("s5 pp cnt",  32'(bus.count), 32'd3);
    chk("s5 pp ghr",  32'(bus.ghr_out), 32'h01F);
    chk("s5 pp exmem",32'(bus.exmem_hist), 32'h003);

    // Push racing a mispredict with arch = 0, res_taken = 0.
    do_reset();
    cyc(1,1,0,0,0);
    cyc(1,1,1,0,1);
    chk("s6 ghr_out", 32'(bus.ghr_out), 32'h000);
    chk("s6 count",   32'(bus.count), 32'd0);
    chk("s6 err",     32'(bus.err), 32'd0);

    // Mixed patterned traffic: pointer wrap, overlaps, repairs.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      automatic bit [5:0] b = 6'(i);
      cyc(b % 3 != 2, b[0] ^ b[2], b[0] | b[3], b[1], (i % 7) == 3);
    end

    // Asynchronous reset mid-stream with three checkpoints held.
    do_reset();
    cyc(1,1,0,0,0); cyc(1,0,0,0,0); cyc(1,1,0,0,0);
    chk("s1 pre cnt", 32'(bus.count), 32'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s1 ghr_out", 32'(bus.ghr_out), 32'h0);
    chk("s1 count",   32'(bus.count), 32'h0);
    chk("s1 full",    32'(bus.ckpt_full), 32'h0);
    chk("s1 exmem",   32'(bus.exmem_hist), 32'h0);
    chk("s1 err",     32'(bus.err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1,1,0,0,0);
    chk("s1 post ghr", 32'(bus.ghr_out), 32'h001);
    chk("s1 post cnt", 32'(bus.count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
